// File: rtl/aes_pkg.sv
// aes_pkg: shared AES byte constants, FIPS-197 S-box tables and SubBytes FSM encoding
package aes_pkg;

    localparam int AES_BYTE_W      = 8;
    localparam int AES_STATE_BYTES = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        DONE = 2'd2
    } sb_state_e;

    localparam logic [2047:0] SBOX_FWD_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [2047:0] SBOX_INV_TBL = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    // entry 0 sits in the most significant byte of each table
    function automatic logic [AES_BYTE_W-1:0] sbox_fwd(input logic [AES_BYTE_W-1:0] b);
        return SBOX_FWD_TBL[(255 - int'(b)) * AES_BYTE_W +: AES_BYTE_W];
    endfunction

    function automatic logic [AES_BYTE_W-1:0] sbox_inv(input logic [AES_BYTE_W-1:0] b);
        return SBOX_INV_TBL[(255 - int'(b)) * AES_BYTE_W +: AES_BYTE_W];
    endfunction

endpackage

// File: rtl/sbox_dual.sv
// sbox_dual: combinational forward/inverse AES S-box lookup for one byte
module sbox_dual
    import aes_pkg::*;
(
    input  logic                  i_inverse,
    input  logic [AES_BYTE_W-1:0] i_byte,
    output logic [AES_BYTE_W-1:0] o_byte
);

    assign o_byte = i_inverse ? sbox_inv(i_byte) : sbox_fwd(i_byte);

endmodule

// File: rtl/sub_bytes_engine.sv
// sub_bytes_engine: iterative AES (Inv)SubBytes over a state word, SBOX_PAR bytes per cycle
module sub_bytes_engine
    import aes_pkg::*;
#(
    parameter int NUM_BYTES = AES_STATE_BYTES,
    parameter int SBOX_PAR  = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic                            in_inverse,
    input  logic [AES_BYTE_W*NUM_BYTES-1:0] in_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [AES_BYTE_W*NUM_BYTES-1:0] out_data,
    output logic                            out_inverse,
    output logic                            busy
);

    localparam int            IW   = $clog2(NUM_BYTES);
    localparam logic [IW-1:0] LAST = IW'(NUM_BYTES - SBOX_PAR);
    localparam logic [IW-1:0] STEP = IW'(SBOX_PAR);

    if (SBOX_PAR < 1 || SBOX_PAR > NUM_BYTES || NUM_BYTES % (SBOX_PAR < 1 ? 1 : SBOX_PAR) != 0) begin : g_bad_par
        $fatal(1, "sub_bytes_engine: SBOX_PAR must be 1..NUM_BYTES and divide NUM_BYTES");
    end

    sb_state_e                                r_state, w_state_nxt;
    logic [IW-1:0]                            r_cnt;
    logic [NUM_BYTES-1:0][AES_BYTE_W-1:0]     r_data, w_data_nxt;
    logic [AES_BYTE_W*NUM_BYTES-1:0]          r_out;
    logic                                     r_inv, r_out_inv, w_accept, w_last;
    logic [AES_BYTE_W-1:0]                    w_sb_in  [SBOX_PAR];
    logic [AES_BYTE_W-1:0]                    w_sb_out [SBOX_PAR];

    assign in_ready    = (r_state == IDLE) | ((r_state == DONE) & out_ready);
    assign w_accept    = in_valid & in_ready;
    assign w_last      = r_cnt == LAST;
    assign out_data    = r_out;
    assign out_inverse = r_out_inv;

    for (genvar j = 0; j < SBOX_PAR; j++) begin : g_sbox
        assign w_sb_in[j] = r_data[r_cnt + IW'(j)];
        sbox_dual u_sbox (
            .i_inverse (r_inv),
            .i_byte    (w_sb_in[j]),
            .o_byte    (w_sb_out[j])
        );
    end

    always_comb begin
        w_data_nxt = r_data;
        for (int i = 0; i < SBOX_PAR; i++) w_data_nxt[r_cnt + IW'(i)] = w_sb_out[i];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // DONE with out_ready and in_valid takes the next word directly, skipping IDLE
    always_comb begin
        w_state_nxt = r_state;
        out_valid   = r_state == DONE;
        busy        = r_state != IDLE;
        if (r_state == IDLE && w_accept) w_state_nxt = SUB;
        if (r_state == SUB && w_last)    w_state_nxt = DONE;
        if (r_state == DONE && out_ready) w_state_nxt = in_valid ? SUB : IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_data    <= '0;
            r_inv     <= 1'b0;
            r_out     <= '0;
            r_out_inv <= 1'b0;
        end else if (w_accept) begin
            r_data <= in_data;
            r_inv  <= in_inverse;
            r_cnt  <= '0;
        end else if (r_state == SUB) begin
            r_data <= w_data_nxt;
            r_cnt  <= w_last ? r_cnt : r_cnt + STEP;
            if (w_last) begin
                r_out     <= w_data_nxt;
                r_out_inv <= r_inv;
            end
        end
    end

endmodule

// File: tb/tb_sub_bytes_engine.sv
// tb_sub_bytes_engine: checks three engine widths (SBOX_PAR 4, 1, 16) against a GF(2^8) reference model
module tb_sub_bytes_engine;

    localparam int NI = 3;
    localparam logic [127:0] T2_IN  = 128'h0f0e0d0c0b0a09080706050403020100;
    localparam logic [127:0] T2_INV = 128'hfbd7f3819ea340bf38a53630d56a0952;
    localparam logic [127:0] T2_FWD = 128'h76abd7fe2b670130c56f6bf27b777c63;

    logic          clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, in_inverse = 1'b0, out_ready = 1'b0;
    logic [127:0]  in_data = '0;
    logic [NI-1:0] ir, ov, oi, bz;
    logic [127:0]  od [NI];
    logic [7:0]    fwd_t [256];
    logic [7:0]    inv_t [256];
    int            n_chk = 0, n_err = 0;

    bit            m_has  [NI];
    int            m_cnt  [NI];
    logic [127:0]  m_pend [NI];
    logic [127:0]  m_eo   [NI];
    logic          m_pinv [NI];
    logic          m_eoi  [NI];

    always #5 clk = ~clk;

    for (genvar k = 0; k < NI; k++) begin : g_dut
        sub_bytes_engine #(.NUM_BYTES(16), .SBOX_PAR(k == 0 ? 4 : k == 1 ? 1 : 16)) u_dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .in_valid    (in_valid),
            .in_ready    (ir[k]),
            .in_inverse  (in_inverse),
            .in_data     (in_data),
            .out_valid   (ov[k]),
            .out_ready   (out_ready),
            .out_data    (od[k]),
            .out_inverse (oi[k]),
            .busy        (bz[k])
        );
    end

    function automatic int lat(input int k);
        return k == 0 ? 4 : k == 1 ? 16 : 1;
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        return 8'((v << n) | (v >> (8 - n)));
    endfunction

    function automatic logic [127:0] sub_word(input logic [127:0] d, input logic inv);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = inv ? inv_t[d[8*i +: 8]] : fwd_t[d[8*i +: 8]];
        return r;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // reference: each accepted word becomes visible lat(k) edges later and holds until taken
    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < NI; k++) begin
            if (!rst_n) begin
                m_has[k] <= 1'b0;
                m_cnt[k] <= 0;
                m_eo[k]  <= '0;
                m_eoi[k] <= 1'b0;
            end else begin
                automatic bit done = m_has[k] && m_cnt[k] >= lat(k);
                automatic bit rdy  = !m_has[k] || (done && out_ready);
                if (in_valid && rdy) begin
                    m_has[k]  <= 1'b1;
                    m_cnt[k]  <= 0;
                    m_pend[k] <= sub_word(in_data, in_inverse);
                    m_pinv[k] <= in_inverse;
                end else if (done && out_ready) begin
                    m_has[k] <= 1'b0;
                end else if (m_has[k] && !done) begin
                    m_cnt[k] <= m_cnt[k] + 1;
                    if (m_cnt[k] + 1 == lat(k)) begin
                        m_eo[k]  <= m_pend[k];
                        m_eoi[k] <= m_pinv[k];
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < NI; k++) begin
            automatic bit done = m_has[k] && m_cnt[k] >= lat(k);
            chk($sformatf("out_valid[%0d]", k), ov[k], done);
            chk($sformatf("in_ready[%0d]", k), ir[k], !m_has[k] || (done && out_ready));
            chk($sformatf("busy[%0d]", k), bz[k], m_has[k]);
            chk($sformatf("out_data[%0d]", k), od[k], m_eo[k]);
            chk($sformatf("out_inverse[%0d]", k), oi[k], m_eoi[k]);
        end
    end

    task automatic send(input logic [127:0] d, input logic inv);
        in_data    = d;
        in_inverse = inv;
        in_valid   = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (ov !== 3'b111 && n < 40) begin
            @(posedge clk);
            #1 n++;
        end
        chk("done timeout", ov, 3'b111);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int x = 0; x < 256; x++) begin
            automatic logic [7:0] b, s;
            b = 8'h01;
            for (int e = 0; e < 254; e++) b = gmul(b, 8'(x));
            s = b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
            fwd_t[x] = s;
            inv_t[s] = 8'(x);
        end
        chk("model fwd 00", fwd_t[8'h00], 8'h63);
        chk("model fwd 53", fwd_t[8'h53], 8'hed);
        chk("model inv 00", inv_t[8'h00], 8'h52);
        chk("model inv 0f", inv_t[8'h0f], 8'hfb);

        repeat (2) @(posedge clk);
        #1;
        chk("reset out_valid", ov, 3'b000);
        chk("reset busy", bz, 3'b000);
        chk("reset out_inverse", oi, 3'b000);
        chk("reset out_data", od[0], '0);
        chk("reset in_ready", ir, 3'b111);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        send('0, 1'b0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("t1 not early", ov[0], 1'b0);
        @(posedge clk);
        #1;
        chk("t1 latency", ov[0], 1'b1);
        chk("t1 data", od[0], {16{8'h63}});
        chk("t1 mode", oi[0], 1'b0);
        wait_done();

        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_inverse = i[0];
            in_data    = {4{$urandom}};
            @(posedge clk);
            #1;
        end
        chk("bp data", od[0], {16{8'h63}});
        chk("bp in_ready", ir, 3'b000);
        chk("bp mode", oi, 3'b000);
        chk("bp valid", ov, 3'b111);

        in_data    = T2_IN;
        in_inverse = 1'b1;
        out_ready  = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("b2b busy", bz, 3'b111);
        chk("b2b in_ready", ir, 3'b000);
        wait_done();
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("t2 data inst %0d", k), od[k], T2_INV);
            chk($sformatf("t2 mode inst %0d", k), oi[k], 1'b1);
        end
        drain();

        for (int w = 0; w < 16; w++) begin
            automatic logic [127:0] orig, fw;
            for (int i = 0; i < 16; i++) orig[8*i +: 8] = 8'(w * 16 + i);
            fw = sub_word(orig, 1'b0);
            send(orig, 1'b0);
            wait_done();
            drain();
            send(fw, 1'b1);
            wait_done();
            for (int k = 0; k < NI; k++) chk($sformatf("round trip w%0d inst %0d", w, k), od[k], orig);
            drain();
        end

        send(T2_IN, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("mid reset out_valid", ov, 3'b000);
        chk("mid reset busy", bz, 3'b000);
        chk("mid reset out_data", od[0], '0);
        chk("mid reset out_data p16", od[2], '0);
        chk("mid reset in_ready", ir, 3'b111);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(T2_IN, 1'b0);
        wait_done();
        for (int k = 0; k < NI; k++) chk($sformatf("post reset inst %0d", k), od[k], T2_FWD);
        drain();

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
